register_dump_engine: RTL
=========================

# register_dump_engine

Debug read-out block that walks every architected register of the register file and streams it out as a byte stream over a valid/ready handshake. It sits beside the register file: it drives a dedicated read port (address plus read enable, one-cycle read latency) and feeds a debug transport such as a UART TX FIFO. It uses the register file's encoding: R0–R7, ACC, DBAR, DOFF, IBAR, IOFF, STATUS. Unused encodings 4'b1011 and 4'b1100 are skipped.

## Interface
- DATA_WIDTH, 8, register width; must be 8. The output byte carries one full register.
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- dump_req_i  in  1  start a dump; sampled only in IDLE
- abort_i  in  1  terminate the dump; return to IDLE next cycle
- busy_o  out  1  high from the cycle after acceptance until return to IDLE
- done_o  out  1  one-cycle pulse after the final byte is accepted
- rf_rd_en_o  out  1  read strobe to the register file read port
- rf_rd_addr_o  out  4  register address, encoded as reg_addr_e
- rf_rd_data_i  in  DATA_WIDTH  read data, valid the cycle after rf_rd_en_o
- out_valid_o  out  1  output byte valid
- out_ready_i  in  1  sink accepts the byte when valid and ready are both high
- out_data_o  out  8  output byte
- out_last_o  out  1  marks the final byte of the dump

## Operation
- Frame: 14 records, 28 bytes in total. Each record is an address byte {4'h0, addr} followed by a data byte (the register value).
- Address order: 0,1,…,10,13,14,15. After address 10 the index jumps to 13. STATUS (15) is always last.
- out_last_o is high only with the STATUS data byte.
- States:
  - IDLE: dump_req_i=1 → READ, with index = 0.
  - READ: rf_rd_en_o=1 and rf_rd_addr_o=index → CAPTURE.
  - CAPTURE: latch rf_rd_data_i into the data register → SEND_ADDR.
  - SEND_ADDR: on handshake → SEND_DATA.
  - SEND_DATA: on handshake, if index=15 → DONE; otherwise advance the index and go to READ.
  - DONE: done_o=1 → IDLE.
- Each register value is captured exactly once. The captured value is held unchanged while waiting for ready, so register writes during back-pressure do not alter bytes already captured.
- Valid stability: once out_valid_o rises, out_data_o and out_last_o hold until the handshake. Abort is the only exception.
- abort_i is honoured in every non-IDLE state and has priority over a handshake in the same cycle.
  - Next cycle: IDLE, out_valid_o=0, busy_o=0, no done_o.
  - A byte whose handshake coincided with the abort counts as not sent.
- dump_req_i while busy: ignored, not queued. dump_req_i and abort_i together in IDLE: the request is accepted and the abort is ignored.
- dump_req_i held high through DONE: a new dump starts from the IDLE cycle that follows DONE.
- rf_rd_en_o is high only in READ. rf_rd_addr_o holds its last value otherwise.

## Timing
- Reset values of outputs:
  - busy_o, done_o, rf_rd_en_o, out_valid_o, out_last_o: 0.
  - out_data_o: 8'h00. rf_rd_addr_o: 4'h0.
  - State IDLE, index 0.
- Reset asserted mid-dump: every output returns to its reset value immediately (asynchronously). The first edge after release is in IDLE.
- Request accepted at edge T: busy_o=1 and rf_rd_en_o=1 during cycle T+1. First out_valid_o in cycle T+3.
- With out_ready_i held high:
  - 4 cycles per register, 56 cycles in total.
  - done_o is in cycle T+57. busy_o falls at T+58.
- Back-pressure adds one cycle per ready-low cycle of a valid byte. No byte is dropped or duplicated.
- done_o overlaps busy_o (busy_o stays high during DONE).

## Test plan
- Preload R0..R7=8'h10..8'h17, ACC=8'hA5, DBAR=8'h01, DOFF=8'h02, IBAR=8'h03, IOFF=8'h04, STATUS=8'h0B; pulse dump_req_i with ready=1 → 28 bytes 00,10,01,11,…,08,A5,…,0A,02,0D,03,0E,04,0F,0B. out_last only on the final 0B. done_o exactly 56 cycles after busy_o rises.
- Random ready (≈50% low) → same 28-byte sequence. Data and last stable while valid&&!ready. rf_rd_en_o asserted exactly 14 times. Addresses 11 and 12 never driven.
- Write ACC=8'hFF while the ACC address byte is stalled after capture → data byte still A5. The next dump reports FF.
- abort_i in the cycle the DOFF data byte handshakes → out_valid_o=0 and busy_o=0 next cycle, done_o never pulses. A fresh request then restarts from the R0 address byte 8'h00.
- dump_req_i pulsed while busy → no effect: exactly 28 bytes and one done_o.
- rst_n low while out_valid_o=1 mid-frame → all outputs zero without a clock edge. After release, idle until the next request, which produces a full 28-byte frame.

Source files
------------

// File: rtl/register_dump_engine.sv
// Debug register dump: walks the architected register file through a dedicated
// one-cycle-latency read port and streams {addr, data} byte pairs over valid/ready.
`timescale 1ns/1ps
module register_dump_engine #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dump_req_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  rf_rd_en_o,
  output logic [3:0]            rf_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rf_rd_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [7:0]            out_data_o,
  output logic                  out_last_o
);

  typedef enum logic [3:0] {
    R0 = 4'd0, R1 = 4'd1, R2 = 4'd2, R3 = 4'd3,
    R4 = 4'd4, R5 = 4'd5, R6 = 4'd6, R7 = 4'd7,
    ACC = 4'd8, DBAR = 4'd9, DOFF = 4'd10,
    IBAR = 4'd13, IOFF = 4'd14, STATUS = 4'd15
  } reg_addr_e;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_SEND_ADDR, S_SEND_DATA, S_DONE
  } state_e;

  state_e                state_q, state_d;
  reg_addr_e             idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  hs;

  // Encodings 11 and 12 are unused, so DOFF is followed directly by IBAR.
  function automatic reg_addr_e next_idx(input reg_addr_e cur);
    if (cur == DOFF) return IBAR;
    return reg_addr_e'(4'(cur) + 4'd1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= R0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    busy_o       = (state_q != S_IDLE);
    done_o       = (state_q == S_DONE);
    rf_rd_en_o   = (state_q == S_READ);
    rf_rd_addr_o = idx_q;
    out_valid_o  = (state_q == S_SEND_ADDR) || (state_q == S_SEND_DATA);
    out_last_o   = (state_q == S_SEND_DATA) && (idx_q == STATUS);
    out_data_o   = 8'h00;
    if (state_q == S_SEND_ADDR) out_data_o = {4'h0, 4'(idx_q)};
    else if (state_q == S_SEND_DATA) out_data_o = data_q;
  end

  assign hs = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (dump_req_i) begin
          state_d = S_READ;
          idx_d   = R0;
        end
      end
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: begin
        // Single capture per register; later register writes cannot leak in.
        data_d  = rf_rd_data_i;
        state_d = S_SEND_ADDR;
      end
      S_SEND_ADDR: if (hs) state_d = S_SEND_DATA;
      S_SEND_DATA: begin
        if (hs) begin
          if (idx_q == STATUS) state_d = S_DONE;
          else begin
            idx_d   = next_idx(idx_q);
            state_d = S_READ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over any handshake in the same cycle.
    if (abort_i && state_q != S_IDLE) state_d = S_IDLE;
  end

endmodule
